// File: rtl/serial_adder_pkg.sv
// Shared types for the digit-serial adder/comparator: operation codes and FSM states.
package serial_adder_pkg;

  // Encodings 8..15 are undefined and produce a zero result.
  typedef enum logic [3:0] {
    ADDER_ADD = 4'd0,
    ADDER_SUB = 4'd1,
    ADDER_EQ  = 4'd2,
    ADDER_NE  = 4'd3,
    ADDER_LT  = 4'd4,
    ADDER_GE  = 4'd5,
    ADDER_LTU = 4'd6,
    ADDER_GEU = 4'd7
  } adderOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Every op other than ADD computes A + ~B + 1.
  function automatic logic op_inverts_b(input adderOp_t op);
    return op != ADDER_ADD;
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple slice used once per cycle by serial_adder.
module adder_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign sum   = total[DIGIT-1:0];
  assign cout  = total[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract/compare unit: one DIGIT-bit slice per cycle, LSB first.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  adderOp_t         op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output sa_state_t        dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  sa_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             zero_q;
  adderOp_t         op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;

  logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
  logic             dig_cout;
  logic             last_digit;
  logic             lt_flag;
  int               dig_base;

  assign dbg_state  = state_q;
  assign last_digit = (cnt_q == CW'(N - 1));
  assign dig_base   = int'(cnt_q) * DIGIT;
  assign dig_a      = a_q[dig_base +: DIGIT];
  assign dig_b      = b_q[dig_base +: DIGIT] ^ {DIGIT{op_inverts_b(op_q)}};

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_d = RUN;
      end
      RUN: begin
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      op_q    <= ADDER_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q    <= op;
            a_q     <= src_a;
            b_q     <= src_b;
            cnt_q   <= '0;
            carry_q <= op_inverts_b(op);
            zero_q  <= 1'b1;
          end
        end
        RUN: begin
          res_q[dig_base +: DIGIT] <= dig_sum;
          carry_q <= dig_cout;
          zero_q  <= zero_q & ~(|dig_sum);
          cnt_q   <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Sign of the (WIDTH+1)-bit signed difference A - B.
  assign lt_flag = a_q[WIDTH-1] ^ ~b_q[WIDTH-1] ^ carry_q;

  always_comb begin
    out  = '0;
    cout = 1'b0;
    if (state_q == DONE) begin
      case (op_q)
        ADDER_ADD, ADDER_SUB: begin
          out  = res_q;
          cout = carry_q;
        end
        ADDER_EQ:  begin out = WIDTH'(zero_q);   cout = carry_q; end
        ADDER_NE:  begin out = WIDTH'(!zero_q);  cout = carry_q; end
        ADDER_LT:  begin out = WIDTH'(lt_flag);  cout = carry_q; end
        ADDER_GE:  begin out = WIDTH'(!lt_flag); cout = carry_q; end
        ADDER_LTU: begin out = WIDTH'(!carry_q); cout = carry_q; end
        ADDER_GEU: begin out = WIDTH'(carry_q);  cout = carry_q; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 32;
  localparam int D = 8;
  localparam int N = W / D;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready;
  adderOp_t     op;
  logic [W-1:0] src_a, src_b;
  logic         in_ready, out_valid, cout;
  logic [W-1:0] out;
  sa_state_t    dbg_state;

  logic         iv32, or32, ir32, ov32, co32;
  logic [W-1:0] out32;
  sa_state_t    st32;
  logic         iv1, or1, ir1, ov1, co1;
  logic [W-1:0] out1;
  sa_state_t    st1;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0] exp_q[$];
  int         m_wait = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .dbg_state(dbg_state)
  );

  serial_adder #(.WIDTH(W), .DIGIT(32)) dut_d32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(ov32), .out_ready(or32),
    .out(out32), .cout(co32), .dbg_state(st32)
  );

  serial_adder #(.WIDTH(W), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(ov1), .out_ready(or1),
    .out(out1), .cout(co1), .dbg_state(st1)
  );

  // Reference: {cout, out} from plain arithmetic on the operands.
  function automatic logic [W:0] ref_calc(input adderOp_t o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic ge;
    ge = (a >= b);
    case (o)
      ADDER_ADD: return {1'b0, a} + {1'b0, b};
      ADDER_SUB: return {ge, a - b};
      ADDER_EQ:  return {ge, W'(a == b)};
      ADDER_NE:  return {ge, W'(a != b)};
      ADDER_LT:  return {ge, W'($signed(a) < $signed(b))};
      ADDER_GE:  return {ge, W'($signed(a) >= $signed(b))};
      ADDER_LTU: return {ge, W'(a < b)};
      ADDER_GEU: return {ge, W'(ge)};
      default:   return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: idle when no result is queued; running while m_wait > 0; done otherwise.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_wait = 0;
    end else if (exp_q.size() == 0) begin
      if (in_valid) begin
        exp_q.push_back(ref_calc(op, src_a, src_b));
        m_wait = N;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (out_ready) begin
      void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out", 64'({cout, out}), 64'(0));
    end else begin
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0 && m_wait == 0));
      if (exp_q.size() > 0 && m_wait == 0)
        chk("result", 64'({cout, out}), 64'(exp_q[0]));
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    out_ready = 1'b0;
    if (t >= 200) chk("idle_timeout", 64'(t), 64'(0));
  endtask

  task automatic run_op(input adderOp_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] exp, input int hold, input string name);
    int lat;
    wait_idle();
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    op = adderOp_t'(4'($urandom_range(0, 15)));
    src_a = $urandom; src_b = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(N));
    chk(name, 64'({cout, out}), 64'(exp));
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      op = adderOp_t'(4'($urandom_range(0, 7)));
      src_a = $urandom;
      step();
      chk({name, "_hold"}, 64'({cout, out}), 64'(exp));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic aux_run(input int sel, input int exp_lat);
    int lat;
    logic ov;
    op = ADDER_ADD; src_a = 32'h7FFF_FFFF; src_b = 32'h0000_0001;
    if (sel == 0) iv32 = 1'b1; else iv1 = 1'b1;
    step();
    iv32 = 1'b0; iv1 = 1'b0;
    src_a = $urandom; src_b = $urandom;
    lat = 0;
    ov = 1'b0;
    while (!ov && lat < 100) begin
      step();
      lat++;
      ov = (sel == 0) ? ov32 : ov1;
    end
    chk((sel == 0) ? "d32_latency" : "d1_latency", 64'(lat), 64'(exp_lat));
    chk((sel == 0) ? "d32_result" : "d1_result",
        (sel == 0) ? 64'({co32, out32}) : 64'({co1, out1}), 64'({1'b0, 32'h8000_0000}));
    if (sel == 0) or32 = 1'b1; else or1 = 1'b1;
    step();
    or32 = 1'b0; or1 = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = ADDER_ADD;
    src_a = '0; src_b = '0;
    iv32 = 1'b0; or32 = 1'b0; iv1 = 1'b0; or1 = 1'b0;

    chk("model_add_wrap", 64'(ref_calc(ADDER_ADD, 32'hFFFF_FFFF, 32'h1)), 64'({1'b1, 32'h0}));
    chk("model_sub", 64'(ref_calc(ADDER_SUB, 32'h5, 32'h7)), 64'({1'b0, 32'hFFFF_FFFE}));
    chk("model_lt", 64'(ref_calc(ADDER_LT, 32'h8000_0000, 32'h1)), 64'({1'b1, 32'h1}));

    repeat (3) step();
    chk("reset_out", 64'({cout, out}), 64'(0));
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;

    run_op(ADDER_ADD, 32'hFFFF_FFFF, 32'h0000_0001, {1'b1, 32'h0000_0000}, 0, "add_wrap");
    run_op(ADDER_SUB, 32'h0000_0005, 32'h0000_0007, {1'b0, 32'hFFFF_FFFE}, 0, "sub_neg");
    run_op(ADDER_LTU, 32'h0000_0005, 32'h0000_0007, {1'b0, 32'h0000_0001}, 0, "ltu_5_7");
    run_op(ADDER_GEU, 32'h0000_0005, 32'h0000_0007, {1'b0, 32'h0000_0000}, 0, "geu_5_7");
    run_op(ADDER_LT, 32'h8000_0000, 32'h0000_0001, {1'b1, 32'h0000_0001}, 0, "lt_signed");
    run_op(ADDER_LTU, 32'h8000_0000, 32'h0000_0001, {1'b1, 32'h0000_0000}, 0, "ltu_unsigned");
    run_op(ADDER_EQ, 32'h1234_5678, 32'h1234_5678, {1'b1, 32'h0000_0001}, 0, "eq_same");
    run_op(ADDER_NE, 32'h1234_5678, 32'h1234_5678, {1'b1, 32'h0000_0000}, 0, "ne_same");
    run_op(adderOp_t'(4'd11), 32'h1234_5678, 32'h1, {1'b0, 32'h0}, 0, "undef_op");
    run_op(ADDER_ADD, 32'h0000_1111, 32'h0000_2222, {1'b0, 32'h0000_3333}, 10, "stall");

    // Abort in the middle of a run.
    wait_idle();
    op = ADDER_ADD; src_a = 32'h1; src_b = 32'h2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (8) begin
      step();
      chk("abort_no_valid", 64'(out_valid), 64'(0));
    end
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    run_op(ADDER_ADD, 32'h3, 32'h4, {1'b0, 32'h7}, 0, "add_after_abort");

    aux_run(0, 1);
    aux_run(1, 32);

    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = ($urandom_range(0, 9) < 8) ? adderOp_t'(4'($urandom_range(0, 7)))
                                             : adderOp_t'(4'($urandom_range(8, 15)));
      src_a     = rand_val();
      src_b     = ($urandom_range(0, 4) == 0) ? src_a : rand_val();
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    wait_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
